factorial: RTL and testbench

FACTORIAL -- requirements
Module: factorial

---
 rtl/factorial_if.sv | 41 ++++
 rtl/factorial.sv | 124 ++++++++++++
 tb/tb_factorial.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/factorial_if.sv
// rtl/factorial_if.sv - request/result bundle between a factorial requester and the engine
//
// Signals:
//   start     requester -> engine  request a new computation (sampled on rising clk)
//   number    requester -> engine  unsigned operand n, N bits
//   factorial engine -> requester  registered n! modulo 2^OUT_W
//   busy      engine -> requester  high while a computation is running
//   done      engine -> requester  one-cycle pulse marking a fresh result
//   overflow  engine -> requester  true n! of the last result did not fit in OUT_W bits
//
// Modports: master drives the request side, slave (the engine) drives the result side.

interface factorial_if #(
    parameter int N     = 4,
    parameter int OUT_W = 32
);
    logic             start;
    logic [N-1:0]     number;
    logic [OUT_W-1:0] factorial;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start,
        output number,
        input  factorial,
        input  busy,
        input  done,
        input  overflow
    );

    modport slave (
        input  start,
        input  number,
        output factorial,
        output busy,
        output done,
        output overflow
    );
endinterface

// File: rtl/factorial.sv
// rtl/factorial.sv - iterative factorial engine, one OUT_W x N multiply per clock
//
// Computes n! by repeated multiplication, counting n down to 1. The operand
// is captured when start is accepted, so later changes on number do not
// disturb a running computation. Results are registered and held until the
// next completion.
//
// Parameters:
//   N      operand width
//   OUT_W  result width (must be >= N)
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset, dominates every other input
//   bus   factorial_if slave modport:
//           start/number           request in
//           factorial/overflow     registered result out
//           busy                   high while in CALC
//           done                   one-cycle completion pulse

module factorial #(
    parameter int N     = 4,
    parameter int OUT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    factorial_if.slave  bus
);

    // Full-precision product width; the bits above OUT_W reveal overflow.
    localparam int P_W = OUT_W + N;

    localparam logic [N-1:0]     CNT_ONE = N'(1);
    localparam logic [OUT_W-1:0] ACC_ONE = OUT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [N-1:0]     cnt_q, cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic [OUT_W-1:0] fact_q, fact_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [P_W-1:0]   prod;
    logic             prod_ovf;

    // Single multiplier, widened so the truncated-away high bits are visible.
    assign prod     = P_W'(acc_q) * P_W'(cnt_q);
    assign prod_ovf = |prod[P_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= ACC_ONE;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            fact_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            fact_q    <= fact_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        fact_d    = fact_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d     = bus.number;
                    acc_d     = ACC_ONE;
                    ovf_int_d = 1'b0;
                    state_d   = CALC;
                end
            end

            CALC: begin
                if (cnt_q > CNT_ONE) begin
                    acc_d = prod[OUT_W-1:0];
                    cnt_d = cnt_q - CNT_ONE;
                    // Sticky: once any partial product wraps, the true n!
                    // cannot fit, even though acc keeps the modulo value.
                    if (prod_ovf) begin
                        ovf_int_d = 1'b1;
                    end
                end else begin
                    // cnt of 0 or 1 finishes with acc unchanged, so 0! = 1! = 1.
                    fact_d  = acc_q;
                    ovf_d   = ovf_int_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.factorial = fact_q;
    assign bus.overflow  = ovf_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == CALC);

endmodule

// File: tb/tb_factorial.sv
// tb/tb_factorial.sv - scoreboard bench for the factorial engine

`timescale 1ns/1ps

module tb_factorial;

    localparam int N     = 4;
    localparam int OUT_W = 32;

    typedef struct {
        logic [31:0] fact;
        logic        ovf;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;

    exp_t sb[$];

    // Quiet-period expectations, set by stimulus and checked by the monitor.
    logic        chk_idle;
    logic [31:0] hold_fact;
    logic        hold_ovf;
    logic        final_chk;

    int vectors;
    int miscompares;

    factorial_if #(.N(N), .OUT_W(OUT_W)) bus ();

    factorial #(.N(N), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, otherwise checks
    // whatever quiet-period expectation the stimulus has armed.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                cmp("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                cmp("factorial", bus.factorial, e.fact);
                cmp("overflow", bus.overflow, e.ovf);
                cmp("done_latency", cyc, e.due);
            end
        end else if (chk_idle) begin
            cmp("idle_busy", bus.busy, 0);
            cmp("hold_factorial", bus.factorial, hold_fact);
            cmp("hold_overflow", bus.overflow, hold_ovf);
        end
        if (final_chk) begin
            cmp("scoreboard_drained", sb.size(), 0);
        end
    end

    // Drive start for one edge (caller is away from the edge) and queue the expectation.
    task automatic start_op(input int n, input logic [31:0] f, input logic ov);
        exp_t e;
        bus.start  = 1'b1;
        bus.number = N'(n);
        @(posedge clk);
        #1;
        e.fact = f;
        e.ovf  = ov;
        e.due  = cyc + ((n < 1) ? 1 : n);
        sb.push_back(e);
        bus.start  = 1'b0;
        bus.number = N'($urandom);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 64; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            $display("FAIL wait_done: got %0d pending expected 0", sb.size());
            $fatal(1, "no done pulse within bound");
        end
    endtask

    task automatic run(input int n, input logic [31:0] f, input logic ov);
        @(negedge clk);
        chk_idle = 1'b0;
        start_op(n, f, ov);
        wait_empty();
        hold_fact = f;
        hold_ovf  = ov;
        chk_idle  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    int          seq_n[8]    = '{0, 1, 4, 5, 3, 8, 9, 6};
    logic [31:0] seq_f[8]    = '{32'd1, 32'd1, 32'd24, 32'd120, 32'd6, 32'd40320, 32'd362880, 32'd720};

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.number  = '0;
        chk_idle    = 1'b0;
        hold_fact   = '0;
        hold_ovf    = 1'b0;
        final_chk   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: everything reads zero and stays there.
        chk_idle = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Sequential directed vectors, latency checked per result.
        for (int i = 0; i < 8; i++) begin
            run(seq_n[i], seq_f[i], 1'b0);
        end

        // Overflow boundary: 12! fits, 13! wraps; the flag clears on the next start.
        run(12, 32'd479001600, 1'b0);
        run(13, 32'd1932053504, 1'b1);
        run(3, 32'd6, 1'b0);

        // Start while busy is ignored; number changes mid-run do not matter.
        @(negedge clk);
        chk_idle = 1'b0;
        start_op(8, 32'd40320, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.number = 4'd3;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.number = 4'd15;
        wait_empty();
        hold_fact = 32'd40320;
        hold_ovf  = 1'b0;
        chk_idle  = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back: restart in the done cycle of the previous result.
        @(negedge clk);
        chk_idle = 1'b0;
        start_op(4, 32'd24, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        start_op(5, 32'd120, 1'b0);
        wait_empty();
        hold_fact = 32'd120;
        hold_ovf  = 1'b0;
        chk_idle  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Abort: reset at the 4th edge of an n=9 run, no done, outputs cleared.
        @(negedge clk);
        chk_idle   = 1'b0;
        bus.start  = 1'b1;
        bus.number = 4'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        hold_fact = '0;
        hold_ovf  = 1'b0;
        chk_idle  = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Normal operation resumes after the abort.
        run(6, 32'd720, 1'b0);

        chk_idle  = 1'b0;
        final_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
